// File: rtl/qspi_psram_pkg.sv
// Shared constants for the QSPI PSRAM responder: opcodes, FSM state encoding, address width.
package qspi_psram_pkg;

    localparam int ADDR_W = 24;

    localparam logic [7:0] OP_QREAD     = 8'hEB;
    localparam logic [7:0] OP_QWRITE    = 8'h38;
    localparam logic [7:0] OP_QPI_ENTER = 8'h35;
    localparam logic [7:0] OP_QPI_EXIT  = 8'hF5;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADDR,
        DUMMY,
        RDATA,
        WDATA,
        IGNORE
    } state_t;

endpackage

// File: rtl/qspi_sync_edge.sv
// Brings the serial-side pins into the clk domain and flags sck / ce_n edges.
module qspi_sync_edge (
    input  logic       clk,
    input  logic       psram_sck,
    input  logic       psram_ce_n,
    input  logic [3:0] psram_d_in,
    output logic       sck_rise,
    output logic       sck_fall,
    output logic       ce_n_sync,
    output logic       ce_fall,
    output logic       ce_rise,
    output logic [3:0] d_sync
);

    // {sck, ce_n, d[3:0]} travel together so data and sck edges stay aligned.
    logic [5:0] meta;
    logic [5:0] sync;
    logic       sck_q;
    logic       ce_q;

    // NOTE: these flops are free-running and never reset, so a ce_n held low
    // across a reset is not mistaken for a fresh chip-select fall afterwards.
    always_ff @(posedge clk) begin
        meta  <= {psram_sck, psram_ce_n, psram_d_in};
        sync  <= meta;
        sck_q <= sync[5];
        ce_q  <= sync[4];
    end

    assign ce_n_sync = sync[4];
    assign d_sync    = sync[3:0];
    assign sck_rise  = sync[5] & ~sck_q;
    assign sck_fall  = ~sync[5] & sck_q;
    assign ce_fall   = ~sync[4] & ce_q;
    assign ce_rise   = sync[4] & ~ce_q;

endmodule

// File: rtl/qspi_psram_responder.sv
// QSPI PSRAM responder: SPI opcode, 24-bit quad address, quad read (0xEB) / write (0x38).
// Defining PSRAM_RESP_QPI_EN adds QPI command mode (0x35 enter, 0xF5 exit).
module qspi_psram_responder
    import qspi_psram_pkg::*;
#(
    parameter int MEM_BYTES    = 4096,
    parameter int DUMMY_CYCLES = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       psram_sck,
    input  logic       psram_ce_n,
    input  logic [3:0] psram_d_in,
    output logic [3:0] psram_d_out,
    output logic [3:0] psram_d_oe,
    output logic       busy,
    output logic       cmd_err
);

    localparam int             PTR_W      = (MEM_BYTES > 1) ? $clog2(MEM_BYTES) : 1;
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(MEM_BYTES - 1);
    localparam logic [7:0]     DUMMY_LAST = 8'(DUMMY_CYCLES - 1);

    logic       sck_rise, sck_fall, ce_n_sync, ce_fall, ce_rise;
    logic [3:0] d_sync;

    qspi_sync_edge u_sync (
        .clk        (clk),
        .psram_sck  (psram_sck),
        .psram_ce_n (psram_ce_n),
        .psram_d_in (psram_d_in),
        .sck_rise   (sck_rise),
        .sck_fall   (sck_fall),
        .ce_n_sync  (ce_n_sync),
        .ce_fall    (ce_fall),
        .ce_rise    (ce_rise),
        .d_sync     (d_sync)
    );

    state_t              state, state_nx;
    logic [7:0]          cnt;
    logic [6:0]          op_sr;
    logic [ADDR_W-5:0]   addr_sr;
    logic [PTR_W-1:0]    ptr;
    logic                half;
    logic [3:0]          wbuf;
    logic                is_read;
    logic [7:0]          mem [MEM_BYTES];
`ifdef PSRAM_RESP_QPI_EN
    logic                qpi_mode;
`endif

    logic [7:0]          op_full;
    logic                op_last;
    logic                op_bad;
    logic [ADDR_W-1:0]   addr_full;
    logic [PTR_W-1:0]    ptr_load, ptr_inc;
    logic [7:0]          rd_byte;
    logic                mem_we;

    assign addr_full = {addr_sr, d_sync};
    assign ptr_load  = PTR_W'(32'(addr_full) % 32'(MEM_BYTES));
    assign ptr_inc   = (ptr == PTR_LAST) ? '0 : ptr + PTR_W'(1);
    assign rd_byte   = mem[ptr];
    assign mem_we    = (state == WDATA) && sck_rise && half && !ce_rise;
    assign busy      = ~(ce_n_sync | rst);

    // NOTE: every signal assigned here gets a default first, so no latch can be inferred.
    always_comb begin
        op_full  = {op_sr, d_sync[0]};
        op_last  = (cnt == 8'd7);
`ifdef PSRAM_RESP_QPI_EN
        if (qpi_mode) begin
            op_full = {op_sr[3:0], d_sync};
            op_last = (cnt == 8'd1);
        end
`endif
        state_nx = state;
        op_bad   = 1'b0;
        if (ce_rise) begin
            state_nx = IDLE;
        end else begin
            case (state)
                IDLE:  if (ce_fall) state_nx = CMD;
                CMD: if (sck_rise && op_last) begin
                    case (op_full)
                        OP_QREAD, OP_QWRITE: state_nx = ADDR;
`ifdef PSRAM_RESP_QPI_EN
                        OP_QPI_ENTER, OP_QPI_EXIT: state_nx = IGNORE;
`endif
                        default: begin
                            state_nx = IGNORE;
                            op_bad   = 1'b1;
                        end
                    endcase
                end
                ADDR: if (sck_rise && cnt == 8'd5) begin
                    if (!is_read)               state_nx = WDATA;
                    else if (DUMMY_CYCLES == 0) state_nx = RDATA;
                    else                        state_nx = DUMMY;
                end
                DUMMY: if (sck_rise && cnt == DUMMY_LAST) state_nx = RDATA;
                default: ;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt         <= '0;
            op_sr       <= '0;
            addr_sr     <= '0;
            ptr         <= '0;
            half        <= 1'b0;
            wbuf        <= '0;
            is_read     <= 1'b0;
            psram_d_out <= '0;
            psram_d_oe  <= '0;
            cmd_err     <= 1'b0;
`ifdef PSRAM_RESP_QPI_EN
            qpi_mode    <= 1'b0;
`endif
        end else begin
            cmd_err <= op_bad;
            if (state_nx != state) cnt <= '0;
            else if (sck_rise)     cnt <= cnt + 8'd1;

            case (state)
                CMD: if (sck_rise) begin
                    op_sr <= op_full[6:0];
                    if (op_last) is_read <= (op_full == OP_QREAD);
`ifdef PSRAM_RESP_QPI_EN
                    if (op_last && op_full == OP_QPI_ENTER) qpi_mode <= 1'b1;
                    if (op_last && op_full == OP_QPI_EXIT)  qpi_mode <= 1'b0;
`endif
                end
                ADDR: if (sck_rise) begin
                    addr_sr <= addr_full[ADDR_W-5:0];
                    if (cnt == 8'd5) ptr <= ptr_load;
                end
                RDATA: if (sck_fall) begin
                    psram_d_oe  <= 4'hF;
                    psram_d_out <= half ? rd_byte[3:0] : rd_byte[7:4];
                    half        <= ~half;
                    if (half) ptr <= ptr_inc;
                end
                WDATA: if (sck_rise) begin
                    half <= ~half;
                    wbuf <= d_sync;
                    if (half) ptr <= ptr_inc;
                end
                default: ;
            endcase

            // Leaving a state drops any half-finished byte and releases the bus.
            if (state_nx != state) half <= 1'b0;
            if (state_nx != RDATA) psram_d_oe <= '0;
        end
    end

    // NOTE: the byte array is deliberately left out of reset; contents survive rst.
    always_ff @(posedge clk) begin
        if (mem_we) mem[ptr] <= {wbuf, d_sync};
    end

endmodule
